// File: rtl/baugh_wooley_div.sv
// Iterative restoring divider with independently signed dividend/divisor, valid/ready on both sides.
// Optional status outputs dz_o/ovf_o are added when BW_DIV_STATUS_EN is defined.
module baugh_wooley_div #(
    parameter int p_width = 4
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               valid_i,
    output logic               ready_o,
    input  logic [p_width-1:0] a_i,
    input  logic [p_width-1:0] b_i,
    input  logic               a_signed_i,
    input  logic               b_signed_i,
    output logic               valid_o,
    input  logic               ready_i,
    output logic [p_width-1:0] q_o,
    output logic [p_width-1:0] r_o
`ifdef BW_DIV_STATUS_EN
    ,
    output logic               dz_o,
    output logic               ovf_o
`endif
);
    localparam int c_cnt_w = $clog2(p_width);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t               state;
    state_t               state_nxt;
    logic [p_width-1:0]   a_raw;
    logic [p_width-1:0]   dvd;
    logic [p_width-1:0]   dvs;
    logic [p_width-1:0]   rem;
    logic [c_cnt_w-1:0]   cnt;
    logic                 neg_q;
    logic                 neg_r;
    logic                 dz;
    logic                 ovf;
    logic                 fix;

    logic                 accept;
    logic                 sa;
    logic                 sb;
    logic [p_width-1:0]   a_mag;
    logic [p_width-1:0]   b_mag;
    logic                 is_dz;
    logic                 is_ovf;
    logic [p_width:0]     trial;
    logic [p_width:0]     diff;
    logic                 ge;
    logic [p_width-1:0]   q_fin;
    logic [p_width-1:0]   r_fin;

    assign ready_o = (state == IDLE);
    assign valid_o = (state == DONE);
    assign accept  = valid_i && ready_o;

    assign sa     = a_signed_i & a_i[p_width-1];
    assign sb     = b_signed_i & b_i[p_width-1];
    assign a_mag  = sa ? -a_i : a_i;
    assign b_mag  = sb ? -b_i : b_i;
    assign is_dz  = (b_i == '0);
    assign is_ovf = a_signed_i & b_signed_i & (&b_i)
                    & (a_i == {1'b1, {(p_width-1){1'b0}}});

    // One restoring step: the borrow out of the (p_width+1)-bit trial subtraction decides the quotient bit.
    assign trial = {rem, dvd[p_width-1]};
    assign diff  = trial - {1'b0, dvs};
    assign ge    = ~diff[p_width];
    assign q_fin = neg_q ? -dvd : dvd;
    assign r_fin = neg_r ? -rem : rem;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = CALC;
            CALC:    if (dz || ovf || fix) state_nxt = DONE;
            DONE:    if (ready_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            a_raw <= '0;
            dvd   <= '0;
            dvs   <= '0;
            rem   <= '0;
            cnt   <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            dz    <= 1'b0;
            ovf   <= 1'b0;
            fix   <= 1'b0;
            q_o   <= '0;
            r_o   <= '0;
`ifdef BW_DIV_STATUS_EN
            dz_o  <= 1'b0;
            ovf_o <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_raw <= a_i;
                        dvd   <= a_mag;
                        dvs   <= b_mag;
                        rem   <= '0;
                        cnt   <= c_cnt_w'(p_width - 1);
                        neg_q <= sa ^ sb;
                        neg_r <= sa;
                        dz    <= is_dz;
                        ovf   <= is_ovf;
                        fix   <= 1'b0;
                    end
                end
                CALC: begin
                    // Special cases bypass the iteration; otherwise the extra cycle after the last step applies signs.
                    if (dz) begin
                        q_o <= '1;
                        r_o <= a_raw;
                    end else if (ovf) begin
                        q_o <= a_raw;
                        r_o <= '0;
                    end else if (fix) begin
                        q_o <= q_fin;
                        r_o <= r_fin;
                    end else begin
                        rem <= ge ? diff[p_width-1:0] : trial[p_width-1:0];
                        dvd <= {dvd[p_width-2:0], ge};
                        if (cnt == '0) begin
                            fix <= 1'b1;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
`ifdef BW_DIV_STATUS_EN
                    if (dz || ovf || fix) begin
                        dz_o  <= dz;
                        ovf_o <= ovf;
                    end
`endif
                end
                DONE: begin
`ifdef BW_DIV_STATUS_EN
                    if (ready_i) begin
                        dz_o  <= 1'b0;
                        ovf_o <= 1'b0;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_baugh_wooley_div.sv
// Scoreboard bench for baugh_wooley_div: directed cases, backpressure, mid-operation reset, exhaustive sweep.
module tb_baugh_wooley_div;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         valid_i;
    logic         ready_o;
    logic [W-1:0] a_i;
    logic [W-1:0] b_i;
    logic         a_signed_i;
    logic         b_signed_i;
    logic         valid_o;
    logic         ready_i;
    logic [W-1:0] q_o;
    logic [W-1:0] r_o;
`ifdef BW_DIV_STATUS_EN
    logic         dz_o;
    logic         ovf_o;
`endif

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        int           lat;
        logic         dz;
        logic         ovf;
        string        tag;
    } exp_t;

    exp_t sb_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    baugh_wooley_div #(.p_width(W)) dut (
        .clk_i(clk),
        .rst_ni(rst_n),
        .valid_i(valid_i),
        .ready_o(ready_o),
        .a_i(a_i),
        .b_i(b_i),
        .a_signed_i(a_signed_i),
        .b_signed_i(b_signed_i),
        .valid_o(valid_o),
        .ready_i(ready_i),
        .q_o(q_o),
        .r_o(r_o)
`ifdef BW_DIV_STATUS_EN
        ,
        .dz_o(dz_o),
        .ovf_o(ovf_o)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: integer division at the operand signedness, truncated to W bits.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic as, input logic bs, input string tag);
        exp_t e;
        int   av;
        int   bv;
        int   qv;
        int   rv;
        av = int'(a);
        bv = int'(b);
        if (as && a[W-1]) av -= (1 << W);
        if (bs && b[W-1]) bv -= (1 << W);
        e.tag = tag;
        e.dz  = 1'b0;
        e.ovf = 1'b0;
        if (bv == 0) begin
            e.q   = '1;
            e.r   = a;
            e.lat = 1;
            e.dz  = 1'b1;
        end else if (as && bs && av == -(1 << (W - 1)) && bv == -1) begin
            e.q   = a;
            e.r   = '0;
            e.lat = 1;
            e.ovf = 1'b1;
        end else begin
            qv    = av / bv;
            rv    = av % bv;
            e.q   = W'(qv);
            e.r   = W'(rv);
            e.lat = W + 1;
        end
        return e;
    endfunction

    // Drives one operation and returns 1 time unit after its accept edge.
    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic as, input logic bs, input string tag,
                                 input bit keep);
        int n;
        n = 0;
        while (!ready_o && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!ready_o) checkOutput({tag, ".ready_wait"}, 32'(ready_o), 32'd1);
        if (keep) sb_q.push_back(model(a, b, as, bs, tag));
        @(negedge clk);
        a_i        = a;
        b_i        = b;
        a_signed_i = as;
        b_signed_i = bs;
        valid_i    = 1'b1;
        @(posedge clk);
        #1;
        valid_i    = 1'b0;
        a_i        = W'($urandom);
        b_i        = W'($urandom);
        a_signed_i = 1'($urandom);
        b_signed_i = 1'($urandom);
    endtask

    task automatic collectResult(input int hold);
        exp_t e;
        int   edges;
        logic [W-1:0] q_seen;
        logic [W-1:0] r_seen;
        edges = 0;
        while (!valid_o && edges < 60) begin
            @(posedge clk);
            #1;
            edges++;
        end
        if (sb_q.size() == 0) begin
            checkOutput("scoreboard_empty", 32'd1, 32'd0);
            return;
        end
        e = sb_q.pop_front();
        if (!valid_o) begin
            checkOutput({e.tag, ".timeout"}, 32'(valid_o), 32'd1);
            return;
        end
        checkOutput({e.tag, ".latency"}, 32'(edges), 32'(e.lat));
        checkOutput({e.tag, ".q"}, 32'(q_o), 32'(e.q));
        checkOutput({e.tag, ".r"}, 32'(r_o), 32'(e.r));
        checkOutput({e.tag, ".ready_in_done"}, 32'(ready_o), 32'd0);
`ifdef BW_DIV_STATUS_EN
        checkOutput({e.tag, ".dz"}, 32'(dz_o), 32'(e.dz));
        checkOutput({e.tag, ".ovf"}, 32'(ovf_o), 32'(e.ovf));
`endif
        q_seen = q_o;
        r_seen = r_o;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            valid_i    = 1'($urandom);
            a_i        = W'($urandom);
            b_i        = W'($urandom);
            a_signed_i = 1'($urandom);
            b_signed_i = 1'($urandom);
            @(posedge clk);
            #1;
            checkOutput({e.tag, ".hold_valid"}, 32'(valid_o), 32'd1);
            checkOutput({e.tag, ".hold_ready"}, 32'(ready_o), 32'd0);
            checkOutput({e.tag, ".hold_q"}, 32'(q_o), 32'(e.q));
            checkOutput({e.tag, ".hold_r"}, 32'(r_o), 32'(e.r));
        end
        @(negedge clk);
        valid_i = 1'b0;
        ready_i = 1'b1;
        @(posedge clk);
        #1;
        ready_i = 1'b0;
        checkOutput({e.tag, ".post_ready"}, 32'(ready_o), 32'd1);
        checkOutput({e.tag, ".post_valid"}, 32'(valid_o), 32'd0);
        checkOutput({e.tag, ".post_q_kept"}, 32'(q_o), 32'(q_seen));
        checkOutput({e.tag, ".post_r_kept"}, 32'(r_o), 32'(r_seen));
`ifdef BW_DIV_STATUS_EN
        checkOutput({e.tag, ".post_dz"}, 32'(dz_o), 32'd0);
        checkOutput({e.tag, ".post_ovf"}, 32'(ovf_o), 32'd0);
`endif
    endtask

    task automatic runOp(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic as, input logic bs, input string tag, input int hold);
        applyStimulus(a, b, as, bs, tag, 1'b1);
        collectResult(hold);
    endtask

    initial begin
        rst_n      = 1'b0;
        valid_i    = 1'b0;
        ready_i    = 1'b0;
        a_i        = '0;
        b_i        = '0;
        a_signed_i = 1'b0;
        b_signed_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset.ready", 32'(ready_o), 32'd1);
        checkOutput("reset.valid", 32'(valid_o), 32'd0);
        checkOutput("reset.q", 32'(q_o), 32'd0);
        checkOutput("reset.r", 32'(r_o), 32'd0);
`ifdef BW_DIV_STATUS_EN
        checkOutput("reset.dz", 32'(dz_o), 32'd0);
        checkOutput("reset.ovf", 32'(ovf_o), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        runOp(4'b0111, 4'b0010, 1'b0, 1'b0, "u7div2", 0);
        runOp(4'b1001, 4'b0010, 1'b1, 1'b1, "sm7div2", 0);
        runOp(4'b0111, 4'b1110, 1'b1, 1'b1, "s7divm2", 0);
        for (int s = 0; s < 4; s++) begin
            runOp(4'b1010, 4'b0000, s[1], s[0], "divzero", 0);
        end
        runOp(4'b1000, 4'b1111, 1'b1, 1'b1, "overflow", 0);
        runOp(4'b1000, 4'b1111, 1'b0, 1'b0, "ovf_unsigned", 0);
        runOp(4'b1011, 4'b0011, 1'b1, 1'b0, "backpressure", 10);

        // Abort an operation two cycles after accept; its result must never appear.
        applyStimulus(4'b0111, 4'b0011, 1'b0, 1'b0, "abort", 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        checkOutput("abort.ready", 32'(ready_o), 32'd1);
        checkOutput("abort.valid", 32'(valid_o), 32'd0);
        checkOutput("abort.q", 32'(q_o), 32'd0);
        checkOutput("abort.r", 32'(r_o), 32'd0);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            checkOutput("abort.no_result", 32'(valid_o), 32'd0);
        end
        runOp(4'b1100, 4'b0011, 1'b0, 1'b0, "after_abort", 0);

        for (int s = 0; s < 4; s++) begin
            for (int a = 0; a < (1 << W); a++) begin
                for (int b = 0; b < (1 << W); b++) begin
                    runOp(W'(a), W'(b), s[1], s[0], "sweep", 0);
                end
            end
        end

        checkOutput("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
